// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and default widths for the RAM responder
package ram_pkg;

    typedef enum logic {INIT, READY} ram_state_t;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset clear sweep: INIT/READY FSM and sweep counter
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else if (state_q == INIT) begin
            if (cnt_q == LAST) begin
                state_q <= READY;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign init_busy = (state_q == INIT);
    assign init_we   = init_busy;
    assign init_addr = cnt_q;
    assign ready     = (state_q == READY);

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - simple dual-port RAM bus responder, write-first reads,
// range checking and a hardware clear sweep after reset
module ram_responder
    import ram_pkg::*;
#(
    parameter int                DATA_W   = RAM_DATA_W,
    parameter int                ADDR_W   = RAM_ADDR_W,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              init_busy,
    output logic              coll,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              ready;

    ram_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_busy (init_busy),
        .ready     (ready)
    );

    logic w_in_range, r_in_range;
    logic w_req, r_req, w_ok, r_ok, collide;

    assign w_in_range = ({1'b0, w_addr} < DEPTH_L);
    assign r_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_req      = ready & cs & w_en;
    assign r_req      = ready & cs & r_en;
    assign w_ok       = w_req & w_in_range;
    assign r_ok       = r_req & r_in_range;
    assign collide    = w_ok & r_ok & (w_addr == r_addr);

    // The sweep owns the single write port until it finishes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign mem_we    = init_we | w_ok;
    assign mem_waddr = init_we ? init_addr : w_addr;
    assign mem_wdata = init_we ? INIT_VAL : w_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] r_data_d, r_data_q;
    logic              r_valid_d, r_valid_q;
    logic              coll_d, coll_q;
    logic              addr_err_d, addr_err_q;

    always_comb begin
        r_data_d   = r_data_q;
        r_valid_d  = r_req;
        coll_d     = collide;
        addr_err_d = (w_req & ~w_in_range) | (r_req & ~r_in_range);
        if (collide) begin
            r_data_d = w_data;
        end else if (r_ok) begin
            r_data_d = mem[r_addr];
        end else if (r_req) begin
            r_data_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            coll_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            r_data_q   <= r_data_d;
            r_valid_q  <= r_valid_d;
            coll_q     <= coll_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign r_data   = r_data_q;
    assign r_valid  = r_valid_q;
    assign coll     = coll_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed self-checking bench for ram_responder
module tb_ram_responder;

    logic       clk;
    int         total;
    int         bad;

    // Instance A: default geometry (16 words)
    logic       rst, cs, w_en, r_en;
    logic [3:0] w_addr, r_addr;
    logic [7:0] w_data, r_data;
    logic       r_valid, init_busy, coll, addr_err;

    // Instance B: partially populated address space (12 words)
    logic       rst_b, cs_b, w_en_b, r_en_b;
    logic [3:0] w_addr_b, r_addr_b;
    logic [7:0] w_data_b, r_data_b;
    logic       r_valid_b, init_busy_b, coll_b, addr_err_b;

    ram_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .cs(cs), .w_en(w_en), .r_en(r_en),
        .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data),
        .r_data(r_data), .r_valid(r_valid), .init_busy(init_busy),
        .coll(coll), .addr_err(addr_err)
    );

    ram_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst_b), .cs(cs_b), .w_en(w_en_b), .r_en(r_en_b),
        .w_addr(w_addr_b), .r_addr(r_addr_b), .w_data(w_data_b),
        .r_data(r_data_b), .r_valid(r_valid_b), .init_busy(init_busy_b),
        .coll(coll_b), .addr_err(addr_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic we, input logic re,
                         input logic [3:0] wa, input logic [3:0] ra, input logic [7:0] wd);
        cs = c; w_en = we; r_en = re; w_addr = wa; r_addr = ra; w_data = wd;
    endtask

    task automatic test_reset;
        int n;
        tick;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 8'h00);
        #1;
        total++;
        if (r_data !== 8'h00 || r_valid !== 1'b0 || coll !== 1'b0 ||
            addr_err !== 1'b0 || init_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got data=%h valid=%b coll=%b err=%b busy=%b expected 00 0 0 0 1",
                     r_data, r_valid, coll, addr_err, init_busy);
        end
        tick;
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            tick;
            total++;
            if (r_valid !== 1'b0) begin
                bad++;
                $display("FAIL sweep_no_valid: got r_valid=%b expected 0 at cycle %0d", r_valid, n);
            end
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL sweep_length: got %0d busy cycles expected 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            r_addr = 4'(i);
            tick;
            total++;
            if (r_data !== 8'h00 || r_valid !== 1'b1) begin
                bad++;
                $display("FAIL sweep_clear[%0d]: got data=%h valid=%b expected 00 1", i, r_data, r_valid);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        tick;
    endtask

    task automatic test_write_read;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 8'hA5);
        tick;
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 8'h00);
        tick;
        total++;
        if (r_data !== 8'hA5 || r_valid !== 1'b1) begin
            bad++;
            $display("FAIL write_read: got data=%h valid=%b expected a5 1", r_data, r_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        tick;
        total++;
        if (r_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse: got r_valid=%b expected 0", r_valid);
        end
        tick;
        total++;
        if (r_data !== 8'hA5 || r_valid !== 1'b0) begin
            bad++;
            $display("FAIL data_hold: got data=%h valid=%b expected a5 0", r_data, r_valid);
        end
    endtask

    task automatic test_collision;
        drive(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 8'h11);
        tick;
        drive(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 8'h3C);
        tick;
        total++;
        if (r_data !== 8'h3C || r_valid !== 1'b1 || coll !== 1'b1) begin
            bad++;
            $display("FAIL collision: got data=%h valid=%b coll=%b expected 3c 1 1", r_data, r_valid, coll);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 8'h00);
        tick;
        total++;
        if (r_data !== 8'h3C || coll !== 1'b0) begin
            bad++;
            $display("FAIL collision_readback: got data=%h coll=%b expected 3c 0", r_data, coll);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] addrs [3];
        logic [7:0] exp   [3];
        addrs[0] = 4'd5; addrs[1] = 4'd7; addrs[2] = 4'd2;
        exp[0]   = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 4'd0, addrs[i], 8'h00);
            tick;
            total++;
            if (r_data !== exp[i] || r_valid !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got data=%h valid=%b expected %h 1", i, r_data, r_valid, exp[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        tick;
        total++;
        if (r_valid !== 1'b0 || r_data !== 8'h00) begin
            bad++;
            $display("FAIL idle: got data=%h valid=%b expected 00 0", r_data, r_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 8'h00);
        tick;
    endtask

    task automatic test_cs_gating;
        drive(1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 8'hFF);
        tick;
        total++;
        if (r_valid !== 1'b0 || r_data !== 8'h3C) begin
            bad++;
            $display("FAIL cs_low_cycle: got data=%h valid=%b expected 3c 0", r_data, r_valid);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 8'h00);
        tick;
        total++;
        if (r_data !== 8'h00 || r_valid !== 1'b1) begin
            bad++;
            $display("FAIL cs_gated_write: got data=%h valid=%b expected 00 1", r_data, r_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        tick;
    endtask

    task automatic test_out_of_range;
        int n;
        cs_b = 1'b0; w_en_b = 1'b0; r_en_b = 1'b0;
        w_addr_b = 4'd0; r_addr_b = 4'd0; w_data_b = 8'h00;
        rst_b = 1'b1;
        tick;
        rst_b = 1'b0;
        n = 0;
        while (init_busy_b === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        total++;
        if (n != 12) begin
            bad++;
            $display("FAIL oor_sweep_length: got %0d busy cycles expected 12", n);
        end
        cs_b = 1'b1; w_en_b = 1'b1; w_addr_b = 4'd4; w_data_b = 8'h42;
        tick;
        w_en_b = 1'b0; r_en_b = 1'b1; r_addr_b = 4'd4;
        tick;
        total++;
        if (r_data_b !== 8'h42 || addr_err_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_setup: got data=%h err=%b expected 42 0", r_data_b, addr_err_b);
        end
        w_en_b = 1'b1; w_addr_b = 4'd13; w_data_b = 8'h77; r_addr_b = 4'd14;
        tick;
        total++;
        if (addr_err_b !== 1'b1 || r_valid_b !== 1'b1 || r_data_b !== 8'h00) begin
            bad++;
            $display("FAIL oor_both: got err=%b valid=%b data=%h expected 1 1 00", addr_err_b, r_valid_b, r_data_b);
        end
        w_en_b = 1'b0; r_addr_b = 4'd13;
        tick;
        total++;
        if (addr_err_b !== 1'b1 || r_data_b !== 8'h00) begin
            bad++;
            $display("FAIL oor_read13: got err=%b data=%h expected 1 00", addr_err_b, r_data_b);
        end
        w_en_b = 1'b1; w_addr_b = 4'd11; w_data_b = 8'h55; r_addr_b = 4'd12;
        tick;
        total++;
        if (addr_err_b !== 1'b1 || r_data_b !== 8'h00 || coll_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_read12_write11: got err=%b data=%h coll=%b expected 1 00 0", addr_err_b, r_data_b, coll_b);
        end
        w_en_b = 1'b0; r_addr_b = 4'd11;
        tick;
        total++;
        if (addr_err_b !== 1'b0 || r_data_b !== 8'h55 || r_valid_b !== 1'b1) begin
            bad++;
            $display("FAIL last_word: got err=%b data=%h valid=%b expected 0 55 1", addr_err_b, r_data_b, r_valid_b);
        end
        r_en_b = 1'b0;
        tick;
        total++;
        if (addr_err_b !== 1'b0 || r_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL oor_quiet: got err=%b valid=%b expected 0 0", addr_err_b, r_valid_b);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 8'h00);
        tick;
        total++;
        if (r_data !== 8'hA5 || r_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_read: got data=%h valid=%b expected a5 1", r_data, r_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if (r_data !== 8'h00 || r_valid !== 1'b0 || init_busy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got data=%h valid=%b busy=%b expected 00 0 1", r_data, r_valid, init_busy);
        end
        tick;
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL resweep_length: got %0d busy cycles expected 16", n);
        end
        tick;
        total++;
        if (r_data !== 8'h00 || r_valid !== 1'b1) begin
            bad++;
            $display("FAIL resweep_clear: got data=%h valid=%b expected 00 1", r_data, r_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        tick;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00);
        cs_b = 1'b0; w_en_b = 1'b0; r_en_b = 1'b0;
        w_addr_b = 4'd0; r_addr_b = 4'd0; w_data_b = 8'h00;
        test_reset;
        test_write_read;
        test_collision;
        test_back_to_back;
        test_cs_gating;
        test_out_of_range;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Synthesizable RAM that serves as the responder on the team's RAM bus: it samples cs/w_en/r_en/w_addr/r_addr/w_data and returns r_data.
- Simple dual-port: one write port and one read port, usable in the same cycle.
- Reads are registered, and a same-address read and write in one cycle returns the new data (write-first).
- After every reset, a hardware sweep clears the array before any bus traffic is accepted.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- INIT_VAL, 0, value written to every word during the post-reset sweep. Width is DATA_W.

Ports:
- clk, input, 1, the single clock. All logic is on its rising edge.
- rst, input, 1, reset, asynchronous and active-high.
- cs, input, 1, chip select. When low, the bus is ignored.
- w_en, input, 1, write request.
- r_en, input, 1, read request.
- w_addr, input, ADDR_W, write address.
- r_addr, input, ADDR_W, read address.
- w_data, input, DATA_W, write data.
- r_data, output, DATA_W, registered read data.
- r_valid, output, 1, one-cycle pulse that qualifies r_data.
- init_busy, output, 1, high while the clear sweep runs. The bus is ignored while it is high.
- coll, output, 1, one-cycle pulse for a same-address read/write collision.
- addr_err, output, 1, one-cycle pulse for an access to an address >= DEPTH.

Behaviour:
- Reset:
  - Asserting rst immediately forces r_data=0, r_valid=0, coll=0, addr_err=0, init_busy=1, state=INIT, sweep counter=0.
  - Array contents are not reset directly.
- INIT state:
  - One word is written per clock: mem[cnt] <= INIT_VAL, then cnt increments.
  - After the write to DEPTH-1, the state moves to READY and init_busy goes to 0 on that same edge.
  - The sweep therefore takes exactly DEPTH cycles.
  - All bus inputs are ignored. r_valid, coll and addr_err stay 0.
- Reset during INIT or READY restarts the sweep from address 0.
- READY, write: on an edge where cs=1, w_en=1 and w_addr<DEPTH, mem[w_addr] <= w_data.
- READY, read: on an edge where cs=1, r_en=1 and r_addr<DEPTH:
  - r_data <= mem[r_addr] and r_valid <= 1 on that same edge, giving 1-cycle latency.
  - r_data is visible in the cycle following the request.
- Collision: cs=1, w_en=1, r_en=1 and w_addr==r_addr<DEPTH.
  - The write happens as normal.
  - r_data <= w_data (write-first), r_valid <= 1, coll <= 1.
- Address error: cs=1 with an enabled port whose address is >= DEPTH.
  - Out-of-range write: dropped.
  - Out-of-range read: r_data <= 0 and r_valid <= 1.
  - addr_err <= 1 in either case, once per cycle even if both ports are out of range.
  - The other, in-range port proceeds normally.
- No read this cycle (cs=0, r_en=0 or INIT): r_valid <= 0 and r_data holds its previous value.
- coll and addr_err are 0 in any cycle where their condition is absent.
- Back-to-back reads every cycle are supported, with r_valid held high continuously.
- Both enables low with cs=1 is idle.

Decomposition:
- Shared package ram_pkg:
  - typedef enum logic {INIT, READY} ram_state_t.
  - Default constants RAM_DATA_W=8 and RAM_ADDR_W=4.
- Sub-module ram_init_seq owns the INIT/READY FSM and the sweep counter, with these outputs:
  - init_we
  - init_addr
  - init_busy
  - ready
- ram_responder muxes the sweep write onto the array write port while init_busy is high. It holds the array, the read register, and the collision and error logic.

Test Plan:
- Reset sweep: pulse rst, then drive cs=1, r_en=1, r_addr=3 during INIT.
  - Required: init_busy is high for exactly 16 cycles and r_valid stays 0.
  - Then read addresses 0..15 and require r_data=0 for each.
- Write then read: write 8'hA5 to address 5, and on the next cycle read address 5.
  - Required: one cycle later r_data=8'hA5 with a single r_valid pulse.
  - r_data still holds 8'hA5 two cycles later with r_valid=0.
- Collision: address 7 holds 8'h11. In one cycle drive w_en=1, r_en=1, w_addr=r_addr=7, w_data=8'h3C.
  - Required: next cycle r_data=8'h3C, r_valid=1, coll=1.
  - A following read of address 7 returns 8'h3C.
- cs gating: with cs=0, attempt a write of 8'hFF to address 2, then read address 2 with cs=1.
  - Required: r_data=0 (the INIT_VAL).
  - During the cs=0 cycle, r_valid=0 and r_data is unchanged.
- Out of range (DEPTH=12): write 8'h77 to address 13 and simultaneously read address 14.
  - Required: addr_err=1, r_valid=1, r_data=0.
  - A read of address 13 afterwards also gives r_data=0 with addr_err=1.
- Reset mid-operation: assert rst while a read of address 5 (holding 8'hA5) is in flight.
  - Required: r_data=0 and r_valid=0 immediately, with no clock edge.
  - init_busy=1 and the sweep restarts.
  - After 16 cycles, address 5 reads back 0.
